// File: rtl/lsu_align_unit_pkg.sv
// Shared load/store encodings and aligner FSM states.
package lsu_align_unit_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        LSU_ST_IDLE  = 1'b0,
        LSU_ST_SPLIT = 1'b1
    } lsu_state_e;

    // Index of the last byte if the access were split: 1 for halfwords,
    // 3 for words, 0 for byte or unknown accesses (which never split).
    function automatic logic [1:0] access_last_idx(input logic is_ld, input logic is_st,
                                                   input logic [2:0] f3);
        logic [1:0] r;
        r = 2'd0;
        if (is_st) begin
            case (f3)
                F3_SH:   r = 2'd1;
                F3_SW:   r = 2'd3;
                default: r = 2'd0;
            endcase
        end else if (is_ld) begin
            case (f3)
                F3_LH, F3_LHU: r = 2'd1;
                F3_LW:         r = 2'd3;
                default:       r = 2'd0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Pipeline request / cache bus bundle around the access aligner.
interface lsu_align_unit_if;
    logic [31:0] address_i;
    logic [31:0] write_data_i;
    logic        is_load_instr_i;
    logic        is_store_instr_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misaligned_o;
    logic [31:0] dc_address_o;
    logic [31:0] dc_write_data_o;
    logic        dc_is_load_o;
    logic        dc_is_store_o;
    logic [2:0]  dc_funct3_o;
    logic [31:0] dc_read_data_i;

    // Aligner side
    modport slave (
        input  address_i, write_data_i, is_load_instr_i, is_store_instr_i, funct3_i,
        input  dc_read_data_i,
        output stall_o, load_data_o, load_valid_o, misaligned_o,
        output dc_address_o, dc_write_data_o, dc_is_load_o, dc_is_store_o, dc_funct3_o
    );

    // Pipeline + cache side
    modport master (
        output address_i, write_data_i, is_load_instr_i, is_store_instr_i, funct3_i,
        output dc_read_data_i,
        input  stall_o, load_data_o, load_valid_o, misaligned_o,
        input  dc_address_o, dc_write_data_o, dc_is_load_o, dc_is_store_o, dc_funct3_o
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a raw load value according to funct3.
module lsu_load_extend
    import lsu_align_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] result
);
    // Extend byte/halfword loads; words and unknown codes pass unchanged
    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  result = {24'b0, raw[7:0]};
            F3_LHU:  result = {16'b0, raw[15:0]};
            default: result = raw;
        endcase
    end
endmodule

// File: rtl/lsu_align_unit.sv
// Memory-stage aligner: passes aligned accesses straight to the cache and
// splits misaligned halfword/word accesses into sequential byte accesses.
module lsu_align_unit
    import lsu_align_unit_pkg::*;
(
    input logic             clk_i,
    input logic             rst_i,
    lsu_align_unit_if.slave bus
);
    lsu_state_e  state_q, state_d;
    logic [1:0]  idx_q, last_q;
    logic [31:0] base_q, wdata_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic [23:0] acc_q;

    logic        req_st, req_ld, req_mis, start, active, is_final, cur_st;
    logic [1:0]  req_last, k, cur_last;
    logic [31:0] cur_base, cur_wdata, ext_raw, ext_data;
    logic [2:0]  cur_f3, ext_f3;
    logic [7:0]  wr_byte, rd_byte;

    // Classify the request; byte 0 uses live inputs, later bytes the latched copies
    always_comb begin
        req_st   = bus.is_store_instr_i;
        req_ld   = bus.is_load_instr_i & ~bus.is_store_instr_i;
        req_last = access_last_idx(req_ld, req_st, bus.funct3_i);
        req_mis  = ((req_last == 2'd1) && bus.address_i[0]) ||
                   ((req_last == 2'd3) && (bus.address_i[1:0] != 2'b00));
        start    = (state_q == LSU_ST_IDLE) && req_mis;
        active   = start || (state_q == LSU_ST_SPLIT);
        if (state_q == LSU_ST_SPLIT) begin
            k = idx_q; cur_base = base_q; cur_wdata = wdata_q;
            cur_f3 = f3_q; cur_st = st_q; cur_last = last_q;
        end else begin
            k = 2'd0; cur_base = bus.address_i; cur_wdata = bus.write_data_i;
            cur_f3 = bus.funct3_i; cur_st = req_st; cur_last = req_last;
        end
        is_final = active && (k == cur_last);
        rd_byte  = bus.dc_read_data_i[7:0];
        case (k)
            2'd0:    wr_byte = cur_wdata[7:0];
            2'd1:    wr_byte = cur_wdata[15:8];
            2'd2:    wr_byte = cur_wdata[23:16];
            default: wr_byte = cur_wdata[31:24];
        endcase
        // Pass-through loads are returned as the cache delivers them
        ext_f3  = F3_LW;
        ext_raw = bus.dc_read_data_i;
        if (active) begin
            ext_f3  = cur_f3;
            ext_raw = (cur_last == 2'd1) ? {16'b0, rd_byte, acc_q[7:0]} : {rd_byte, acc_q};
        end
    end

    lsu_load_extend u_ext (
        .funct3 (ext_f3),
        .raw    (ext_raw),
        .result (ext_data)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= LSU_ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: enter SPLIT on a misaligned request, leave after the last byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_ST_IDLE:  if (req_mis) state_d = LSU_ST_SPLIT;
            LSU_ST_SPLIT: if (idx_q == last_q) state_d = LSU_ST_IDLE;
            default:      state_d = LSU_ST_IDLE;
        endcase
    end

    // Split bookkeeping: latch request on byte 0, step index, collect load bytes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            base_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            st_q    <= 1'b0;
            acc_q   <= 24'd0;
        end else begin
            if (start) begin
                base_q  <= bus.address_i;
                wdata_q <= bus.write_data_i;
                f3_q    <= bus.funct3_i;
                st_q    <= req_st;
                last_q  <= req_last;
            end
            if (active) begin
                idx_q <= is_final ? 2'd0 : k + 2'd1;
                if (!cur_st && !is_final) begin
                    case (k)
                        2'd0:    acc_q[7:0]   <= rd_byte;
                        2'd1:    acc_q[15:8]  <= rd_byte;
                        2'd2:    acc_q[23:16] <= rd_byte;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Outputs: byte access while splitting, otherwise straight pass-through
    always_comb begin
        bus.stall_o         = 1'b0;
        bus.load_data_o     = 32'd0;
        bus.load_valid_o    = 1'b0;
        bus.misaligned_o    = 1'b0;
        bus.dc_address_o    = 32'd0;
        bus.dc_write_data_o = 32'd0;
        bus.dc_is_load_o    = 1'b0;
        bus.dc_is_store_o   = 1'b0;
        bus.dc_funct3_o     = 3'd0;
        if (!rst_i) begin
            bus.load_data_o = ext_data;
            if (active) begin
                bus.dc_address_o    = cur_base + {30'd0, k};
                bus.dc_funct3_o     = cur_st ? F3_SB : F3_LBU;
                bus.dc_write_data_o = cur_st ? {24'd0, wr_byte} : 32'd0;
                bus.dc_is_store_o   = cur_st;
                bus.dc_is_load_o    = !cur_st;
                bus.stall_o         = !is_final;
                bus.misaligned_o    = 1'b1;
                bus.load_valid_o    = !cur_st && is_final;
            end else begin
                bus.dc_address_o    = bus.address_i;
                bus.dc_write_data_o = bus.write_data_i;
                bus.dc_funct3_o     = bus.funct3_i;
                bus.dc_is_store_o   = req_st;
                bus.dc_is_load_o    = req_ld;
                bus.load_valid_o    = req_ld;
            end
        end
    end
endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit with a small byte-addressed cache model.
module tb_lsu_align_unit;
    import lsu_align_unit_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lsu_align_unit_if bus ();

    lsu_align_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    st_t         sq[$];
    logic [31:0] lq[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Combinational cache read (address folded to 8 bits)
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        a0 = bus.dc_address_o[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        case (bus.dc_funct3_o)
            F3_LB:   bus.dc_read_data_i = {{24{mem[a0][7]}}, mem[a0]};
            F3_LBU:  bus.dc_read_data_i = {24'd0, mem[a0]};
            F3_LH:   bus.dc_read_data_i = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            F3_LHU:  bus.dc_read_data_i = {16'd0, mem[a1], mem[a0]};
            default: bus.dc_read_data_i = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard pop for stores/loads, then apply the store to the cache model
    task automatic sb_mon();
        st_t e;
        logic [7:0] a;
        if (rst) return;
        if (bus.dc_is_store_o) begin
            if (sq.size() == 0) chk("st_unexpected", 32'(sq.size()), 32'd1);
            else begin
                e = sq.pop_front();
                chk("st_addr", bus.dc_address_o, e.a);
                chk("st_data", bus.dc_write_data_o, e.d);
                chk("st_f3", 32'(bus.dc_funct3_o), 32'(e.f));
            end
            a = bus.dc_address_o[7:0];
            case (bus.dc_funct3_o)
                F3_SB: mem[a] = bus.dc_write_data_o[7:0];
                F3_SH: begin
                    mem[a] = bus.dc_write_data_o[7:0];
                    mem[a + 8'd1] = bus.dc_write_data_o[15:8];
                end
                F3_SW: begin
                    mem[a] = bus.dc_write_data_o[7:0];
                    mem[a + 8'd1] = bus.dc_write_data_o[15:8];
                    mem[a + 8'd2] = bus.dc_write_data_o[23:16];
                    mem[a + 8'd3] = bus.dc_write_data_o[31:24];
                end
                default: ;
            endcase
        end
        if (bus.load_valid_o) begin
            if (lq.size() == 0) chk("ld_unexpected", 32'(lq.size()), 32'd1);
            else chk("ld_data", bus.load_data_o, lq.pop_front());
        end
    endtask

    task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
        bus.is_load_instr_i  = ld;
        bus.is_store_instr_i = st;
        bus.funct3_i         = f3;
        bus.address_i        = addr;
        bus.write_data_i     = wd;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic settle();
        @(negedge clk);
        sb_mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sb(input logic [31:0] a, input logic [7:0] b);
        st_t e;
        e.a = a; e.d = {24'd0, b}; e.f = F3_SB;
        sq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        st_t e;
        logic [31:0] sw_data;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
        mem[8'h03] = 8'h34; mem[8'h04] = 8'h92;
        mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22; mem[8'h01] = 8'h33; mem[8'h02] = 8'h44;

        // Reset: outputs quiet even with misaligned store / load presented
        req(1'b0, 1'b1, F3_SW, 32'h0000_0021, 32'h1122_3344);
        settle();
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_mis", 32'(bus.misaligned_o), 32'd0);
        chk("rst_dc_st", 32'(bus.dc_is_store_o), 32'd0);
        chk("rst_dc_addr", bus.dc_address_o, 32'd0);
        chk("rst_dc_wd", bus.dc_write_data_o, 32'd0);
        chk("rst_dc_f3", 32'(bus.dc_funct3_o), 32'd0);
        req(1'b1, 1'b0, F3_LW, 32'h0000_0010, 32'd0);
        adv();
        settle();
        chk("rst_ld_valid", 32'(bus.load_valid_o), 32'd0);
        chk("rst_dc_ld", 32'(bus.dc_is_load_o), 32'd0);
        rst = 1'b0;
        idle();
        adv();

        // Aligned LW pass-through
        req(1'b1, 1'b0, F3_LW, 32'h0000_0010, 32'd0);
        lq.push_back(32'hDEADBEEF);
        settle();
        chk("alw_data", bus.load_data_o, 32'hDEADBEEF);
        chk("alw_valid", 32'(bus.load_valid_o), 32'd1);
        chk("alw_stall", 32'(bus.stall_o), 32'd0);
        chk("alw_mis", 32'(bus.misaligned_o), 32'd0);
        adv();

        // Misaligned SW at 0x21 -> four byte stores
        sw_data = 32'h1122_3344;
        req(1'b0, 1'b1, F3_SW, 32'h0000_0021, sw_data);
        for (int k = 0; k < 4; k++) push_sb(32'h21 + k, sw_data[8*k +: 8]);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("sw_stall%0d", k), 32'(bus.stall_o), (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("sw_mis%0d", k), 32'(bus.misaligned_o), 32'd1);
            adv();
        end
        chk("sw_mem21", 32'(mem[8'h21]), 32'h44);
        chk("sw_mem24", 32'(mem[8'h24]), 32'h11);

        // Back-to-back misaligned LH then LHU at 0x03
        req(1'b1, 1'b0, F3_LH, 32'h0000_0003, 32'd0);
        lq.push_back(32'hFFFF9234);
        settle();
        chk("lh_addr0", bus.dc_address_o, 32'h3);
        chk("lh_valid0", 32'(bus.load_valid_o), 32'd0);
        chk("lh_stall0", 32'(bus.stall_o), 32'd1);
        adv();
        settle();
        chk("lh_addr1", bus.dc_address_o, 32'h4);
        chk("lh_stall1", 32'(bus.stall_o), 32'd0);
        chk("lh_data1", bus.load_data_o, 32'hFFFF9234);
        adv();
        req(1'b1, 1'b0, F3_LHU, 32'h0000_0003, 32'd0);
        lq.push_back(32'h0000_9234);
        settle(); adv();
        settle();
        chk("lhu_data1", bus.load_data_o, 32'h0000_9234);
        adv();

        // Misaligned LW wrapping through 0xFFFFFFFF
        req(1'b1, 1'b0, F3_LW, 32'hFFFF_FFFF, 32'd0);
        lq.push_back(32'h4433_2211);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("wrap_addr%0d", k), bus.dc_address_o, 32'hFFFF_FFFF + k);
            chk($sformatf("wrap_f3_%0d", k), 32'(bus.dc_funct3_o), 32'(F3_LBU));
            adv();
        end

        // Misaligned SH at 0x61
        req(1'b0, 1'b1, F3_SH, 32'h0000_0061, 32'h0000_BEEF);
        push_sb(32'h61, 8'hEF);
        push_sb(32'h62, 8'hBE);
        settle(); chk("sh_stall0", 32'(bus.stall_o), 32'd1); adv();
        settle(); chk("sh_stall1", 32'(bus.stall_o), 32'd0); adv();

        // Reset in the middle of a split SW: bytes 2..3 abandoned
        req(1'b0, 1'b1, F3_SW, 32'h0000_0051, 32'hAABB_CCDD);
        push_sb(32'h51, 8'hDD);
        push_sb(32'h52, 8'hCC);
        settle(); adv();
        settle(); adv();
        rst = 1'b1;
        settle();
        chk("mrst_dc_st", 32'(bus.dc_is_store_o), 32'd0);
        chk("mrst_stall", 32'(bus.stall_o), 32'd0);
        adv();
        rst = 1'b0;
        idle();
        settle(); adv();
        chk("mrst_mem52", 32'(mem[8'h52]), 32'hCC);
        chk("mrst_mem53", 32'(mem[8'h53]), 32'h00);
        chk("mrst_mem54", 32'(mem[8'h54]), 32'h00);

        // Aligned SB after reset
        req(1'b0, 1'b1, F3_SB, 32'h0000_0040, 32'h0000_005A);
        e.a = 32'h40; e.d = 32'h5A; e.f = F3_SB;
        sq.push_back(e);
        settle();
        chk("sb_stall", 32'(bus.stall_o), 32'd0);
        chk("sb_dc_st", 32'(bus.dc_is_store_o), 32'd1);
        adv();
        chk("sb_mem40", 32'(mem[8'h40]), 32'h5A);

        // Unknown store funct3 at a misaligned address: pass-through
        req(1'b0, 1'b1, 3'b111, 32'h0000_0033, 32'h1234_5678);
        e.a = 32'h33; e.d = 32'h1234_5678; e.f = 3'b111;
        sq.push_back(e);
        settle();
        chk("unk_mis", 32'(bus.misaligned_o), 32'd0);
        chk("unk_stall", 32'(bus.stall_o), 32'd0);
        chk("unk_f3", 32'(bus.dc_funct3_o), 32'h7);
        adv();
        idle();
        settle(); adv();

        chk("st_queue_left", 32'(sq.size()), 32'd0);
        chk("ld_queue_left", 32'(lq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
